// File: rtl/phase_timer_ctrl.sv
// Phase duration timer for a traffic-light FSM: pulses end-of-phase strobes, shortens green on pedestrian demand.
// Strobes are combinational in the cycle the count reaches the phase duration; config writes apply at the next phase entry.
module phase_timer_ctrl #(
    parameter int CW      = 8,
    parameter int RED_DEF = 2,
    parameter int YEL_DEF = 1,
    parameter int GRN_DEF = 4,
    parameter int GRN_MIN = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          r,
    input  logic          y,
    input  logic          g,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_sel,
    input  logic [CW-1:0] cfg_data,
    input  logic          ped_req,
    output logic          cou2,
    output logic          cou1,
    output logic          cou4,
    output logic          ped_ack,
    output logic          cfg_err,
    output logic          err
);

    typedef enum logic [2:0] {PH_NONE, PH_RED, PH_YEL, PH_GRN, PH_ILL} phase_t;
    typedef enum logic [1:0] {IDLE, COUNT, DONE, FAULT} state_t;

    phase_t        phase, prev_phase;
    state_t        state, state_nx;
    logic [CW-1:0] cnt_q, cnt_nx, dur_q, dur_nx;
    logic [CW-1:0] sh_red, sh_yel, sh_grn, sh_cur;
    logic [CW-1:0] cnt_cur, dur_cur, thr;
    logic          pending_q, cfg_err_q, err_q;
    logic          legal, entry, fire, cfg_ok;

    localparam logic [CW-1:0] GRN_MIN_C = CW'(GRN_MIN);

    always_comb begin
        phase = PH_NONE;
        if (en) begin
            case ({r, y, g})
                3'b000:  phase = PH_NONE;
                3'b100:  phase = PH_RED;
                3'b010:  phase = PH_YEL;
                3'b001:  phase = PH_GRN;
                default: phase = PH_ILL;
            endcase
        end
    end

    always_comb begin
        sh_cur = sh_red;
        case (phase)
            PH_YEL:  sh_cur = sh_yel;
            PH_GRN:  sh_cur = sh_grn;
            default: sh_cur = sh_red;
        endcase
    end

    // An entry counts as cycle 1 of the new phase, so a duration of N strobes in its N-th cycle.
    assign legal   = (phase == PH_RED) || (phase == PH_YEL) || (phase == PH_GRN);
    assign entry   = legal && (state != FAULT) && ((phase != prev_phase) || (state == IDLE));
    assign cnt_cur = entry ? CW'(1) : cnt_q;
    assign dur_cur = entry ? sh_cur : dur_q;
    assign thr     = (phase == PH_GRN && pending_q && GRN_MIN_C < dur_cur) ? GRN_MIN_C : dur_cur;
    assign fire    = legal && (state != FAULT) && (entry || state == COUNT) && (cnt_cur == thr);

    // Combinational strobes are gated by reset so nothing leaks out while it is held low.
    assign cou2    = reset && fire && (phase == PH_RED);
    assign cou1    = reset && fire && (phase == PH_YEL);
    assign cou4    = reset && fire && (phase == PH_GRN);
    assign ped_ack = reset && entry && (phase == PH_RED) && pending_q;
    assign cfg_err = cfg_err_q;
    assign err     = err_q;
    assign cfg_ok  = (cfg_sel != 2'd3) && (cfg_data != '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_q;
        dur_nx   = dur_q;
        if (state == FAULT) begin
            state_nx = FAULT;
        end else if (phase == PH_ILL) begin
            state_nx = FAULT;
        end else if (phase == PH_NONE) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            dur_nx = dur_cur;
            if (fire) begin
                state_nx = DONE;
                cnt_nx   = cnt_cur;
            end else if (entry || state == COUNT) begin
                state_nx = COUNT;
                cnt_nx   = (cnt_cur == '1) ? cnt_cur : cnt_cur + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev_phase <= PH_NONE;
            cnt_q      <= '0;
            dur_q      <= '0;
            pending_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            err_q      <= 1'b0;
            sh_red     <= CW'(RED_DEF);
            sh_yel     <= CW'(YEL_DEF);
            sh_grn     <= CW'(GRN_DEF);
        end else begin
            state      <= state_nx;
            prev_phase <= phase;
            cnt_q      <= cnt_nx;
            dur_q      <= dur_nx;
            pending_q  <= ped_ack ? ped_req : (pending_q | ped_req);
            cfg_err_q  <= cfg_we && !cfg_ok;
            err_q      <= err_q | (phase == PH_ILL);
            if (cfg_we && cfg_ok) begin
                case (cfg_sel)
                    2'd0:    sh_red <= cfg_data;
                    2'd1:    sh_yel <= cfg_data;
                    default: sh_grn <= cfg_data;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// Directed bench for phase_timer_ctrl: one cycle per step, outputs checked at the falling edge.
module tb_phase_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset, en, r, y, g, cfg_we, ped_req;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;
    logic       cou2, cou1, cou4, ped_ack, cfg_err, err;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, OFF = 3'b000;
    // Expected output vector order: {cou2, cou1, cou4, ped_ack, cfg_err, err}
    localparam logic [5:0] O_0  = 6'b000000, O_C2 = 6'b100000, O_C1 = 6'b010000;
    localparam logic [5:0] O_C4 = 6'b001000, O_AK = 6'b000100, O_CE = 6'b000010;
    localparam logic [5:0] O_ER = 6'b000001;

    phase_timer_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .r(r), .y(y), .g(g),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .ped_req(ped_req),
        .cou2(cou2), .cou1(cou1), .cou4(cou4), .ped_ack(ped_ack),
        .cfg_err(cfg_err), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {cou2, cou1, cou4, ped_ack, cfg_err, err};
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = data;
    endtask

    task automatic cyc(input logic e, input logic [2:0] ryg, input logic pr,
                       input logic [5:0] exp, input string tag);
        en      = e;
        {r, y, g} = ryg;
        ped_req = pr;
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
        ped_req = 1'b0;
        cfg_we  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; {r, y, g} = OFF; ped_req = 1'b0;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
        @(negedge clk);
        chk("reset_state", O_0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Default durations: red 2, yellow 1, green 4
        cyc(1, RED, 0, O_0,  "red1_c1");
        cyc(1, RED, 0, O_C2, "red1_c2");
        cyc(1, RED, 0, O_0,  "red1_stall");
        cyc(1, YEL, 0, O_C1, "yel1_c1");
        cyc(1, YEL, 0, O_0,  "yel1_stall");
        wr(2'd2, 8'd6);
        cyc(1, GRN, 0, O_0,  "grn1_c1_wr6");
        cyc(1, GRN, 0, O_0,  "grn1_c2");
        cyc(1, GRN, 0, O_0,  "grn1_c3");
        cyc(1, GRN, 0, O_C4, "grn1_c4_old_dur");
        cyc(1, GRN, 0, O_0,  "grn1_stall");
        cyc(1, RED, 0, O_0,  "red2_c1");
        cyc(1, RED, 0, O_C2, "red2_c2");
        cyc(1, YEL, 0, O_C1, "yel2_c1");
        for (int i = 1; i <= 5; i++) cyc(1, GRN, 0, O_0, "grn2_pre6");
        cyc(1, GRN, 0, O_C4, "grn2_c6_new_dur");
        cyc(1, GRN, 0, O_0,  "grn2_stall");

        // Pedestrian request shortens green to GRN_MIN and is acknowledged on red entry
        cyc(1, RED, 0, O_0,  "red3_c1");
        cyc(1, RED, 0, O_C2, "red3_c2");
        wr(2'd2, 8'd4);
        cyc(1, YEL, 0, O_C1, "yel3_c1_wr4");
        cyc(1, GRN, 1, O_0,  "grn3_c1_ped");
        cyc(1, GRN, 0, O_C4, "grn3_c2_short");
        cyc(1, GRN, 0, O_0,  "grn3_stall");
        cyc(1, RED, 0, O_AK, "red4_ack");
        cyc(1, RED, 0, O_C2, "red4_c2");
        cyc(0, OFF, 0, O_0,  "idle1");
        cyc(1, RED, 0, O_0,  "red5_no_ack");
        cyc(1, RED, 0, O_C2, "red5_c2");

        // Rejected config writes
        wr(2'd3, 8'd5);
        cyc(0, OFF, 0, O_0,  "cfg_sel3");
        wr(2'd0, 8'd0);
        cyc(0, OFF, 0, O_CE, "cfg_err1");
        cyc(0, OFF, 0, O_CE, "cfg_err2");
        cyc(0, OFF, 0, O_0,  "cfg_err_clr");
        cyc(1, RED, 0, O_0,  "red6_c1");
        cyc(1, RED, 0, O_C2, "red6_c2_unchanged");
        wr(2'd2, 8'd6);
        cyc(1, RED, 1, O_0,  "red6_stall_ped");

        // Reset mid-yellow with a pending request
        en = 1'b1; {r, y, g} = YEL; reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_yel", O_0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(1, YEL, 0, O_C1, "yel_after_reset");
        cyc(1, RED, 0, O_0,  "red7_pending_clr");
        cyc(1, RED, 0, O_C2, "red7_c2");
        for (int i = 1; i <= 3; i++) cyc(1, GRN, 0, O_0, "grn4_pre4");
        cyc(1, GRN, 0, O_C4, "grn4_c4_default");

        // Illegal phase latches the fault until reset
        cyc(1, 3'b101, 0, O_0, "ill_phase");
        cyc(1, RED, 0, O_ER, "fault_red1");
        cyc(1, RED, 0, O_ER, "fault_red2");
        cyc(1, YEL, 0, O_ER, "fault_yel");
        reset = 1'b0;
        @(negedge clk);
        chk("fault_reset", O_0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(1, RED, 0, O_0,  "red8_c1");
        cyc(1, RED, 0, O_C2, "red8_c2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/phase_timer_ctrl.md
PHASE_TIMER_CTRL -- requirements
Module: phase_timer_ctrl

Interface
REQ-001 SHALL have parameter CW, default 8: duration counter and config width.
REQ-002 SHALL have parameter RED_DEF, default 2: reset red duration, cycles.
REQ-003 SHALL have parameter YEL_DEF, default 1: reset yellow duration, cycles.
REQ-004 SHALL have parameter GRN_DEF, default 4: reset green duration, cycles.
REQ-005 SHALL have parameter GRN_MIN, default 2: minimum green cycles when a pedestrian request is pending.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port en  input  1  light FSM running (non-IDLE).
REQ-009 SHALL have ports r, y, g  input  1 each  light FSM outputs, expected one-hot when en=1.
REQ-010 SHALL have port cfg_we  input  1  duration write strobe.
REQ-011 SHALL have port cfg_sel  input  2  duration select: 0 red, 1 yellow, 2 green, 3 reserved.
REQ-012 SHALL have port cfg_data  input  CW  duration value, cycles.
REQ-013 SHALL have port ped_req  input  1  pedestrian request, level or pulse.
REQ-014 SHALL have ports cou2, cou1, cou4  output  1 each  end-of-phase pulses for red, yellow, green respectively.
REQ-015 SHALL have port ped_ack  output  1  one-cycle pulse when a pending request is served.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse on rejected config write.
REQ-017 SHALL have port err  output  1  sticky illegal-phase flag.

Function
REQ-018 SHALL decode phase each cycle: RED (r only), YEL (y only), GRN (g only), NONE (en=0 or all zero), ILL (en=1 and >1 of r/y/g).
REQ-019 SHALL implement states IDLE, COUNT, DONE, FAULT.
REQ-020 SHALL in IDLE hold counter at 0; go to COUNT when phase is RED, YEL or GRN.
REQ-021 SHALL on any phase change (registered previous phase differs) clear counter to 1 and reload active duration from shadow register, entering COUNT.
REQ-022 SHALL in COUNT increment counter by 1 per cycle, saturating at 2^CW-1.
REQ-023 SHALL pulse the phase's output (RED->cou2, YEL->cou1, GRN->cou4) for exactly one cycle, combinationally high in the cycle counter equals active duration, then enter DONE.
REQ-024 SHALL in DONE keep all cou outputs low until the next phase change; no repeat pulse if the FSM stalls.
REQ-025 SHALL latch ped_req into a pending bit; pending set with ped_req=1 persists until served.
REQ-026 SHALL in GRN with pending=1 fire cou4 when counter equals min(GRN_MIN, green duration) instead of green duration.
REQ-027 SHALL on entry to RED with pending=1 pulse ped_ack for one cycle and clear pending; ped_req in same cycle re-sets pending.
REQ-028 SHALL on cfg_we with cfg_sel 0-2 and cfg_data!=0 write the shadow register; new value takes effect only at next phase entry.
REQ-029 SHALL on cfg_we with cfg_sel=3 or cfg_data=0 discard write and pulse cfg_err next cycle.
REQ-030 SHALL on phase ILL enter FAULT: set err, force cou outputs low, hold counter; leave only via reset.
REQ-031 SHALL on phase NONE from any non-FAULT state return to IDLE, keeping pending and shadow registers.

Reset
REQ-032 SHALL on reset=0, asynchronously: state IDLE, counter 0, pending 0, cou1/cou2/cou4/ped_ack/cfg_err/err 0, shadows RED_DEF/YEL_DEF/GRN_DEF.
REQ-033 SHALL on reset asserted mid-phase abort counting immediately; after release restart counting from the current phase as a new entry.

Verification
REQ-034 Defaults, en=1 r=1 for 3 cycles -> cou2 high in 2nd cycle of red only; no pulse in 3rd.
REQ-035 Write cfg_sel=2 data=6 during GRN -> current green still pulses cou4 at count 4; next green pulses at count 6.
REQ-036 ped_req pulse during GRN count 1, defaults -> cou4 at count 2; ped_ack pulse on first RED cycle; pending 0 after.
REQ-037 cfg_we sel=3, then sel=0 data=0 -> two cfg_err pulses, shadows unchanged (red still 2).
REQ-038 en=1 r=1 g=1 -> err=1 and stays 1 after phase returns legal; cou outputs 0 until reset.
REQ-039 reset=0 asserted at YEL count 0 with pending=1 -> all outputs 0 within same cycle, pending cleared, shadows at defaults.
